reg_file_dumper: RTL and testbench
==================================

// Module: reg_file_dumper
// PURPOSE
//  Debug/readout engine on the register file's read side. On START it walks every register
//  address and reads each value through one read-address port. It streams {addr,data}
//  beats out over a VALID/READY handshake, then reports DONE with an 8-bit checksum.
//  It sits beside the CPU datapath and shares OUT2ADDRESS through an external mux gated by BUSY.
// PARAMETERS
//  NUM_REGS      8  registers to scan (addresses 0..NUM_REGS-1)
//  ADDR_W        3  register address width; NUM_REGS <= 2**ADDR_W
//  DATA_W        8  register data width
//  SETTLE_CYC    1  cycles the read address is held before REGDATA is sampled (1..3); covers the read path delay
// PORTS
//  CLK        in   1        clock; all state changes on posedge
//  RESET_N    in   1        asynchronous active-low reset
//  START      in   1        pulse/level; begins a scan when idle
//  ABORT      in   1        ends an in-progress scan at the next edge
//  RDADDR     out  ADDR_W   read address driven to the register file read port
//  REGDATA    in   DATA_W   read data returned from the register file
//  BUSY       out  1        high from the START-accept edge until DONE pulses or ABORT takes effect; selects RDADDR at the mux
//  DOUT_VALID out  1        beat valid
//  DOUT_READY in   1        consumer accepts the beat when VALID&READY at posedge
//  DOUT_ADDR  out  ADDR_W   address of the current beat
//  DOUT_DATA  out  DATA_W   register value of the current beat
//  DONE       out  1        one-cycle pulse after the last beat is accepted
//  CHECKSUM   out  DATA_W   mod-2**DATA_W sum of all beats; valid while DONE=1, held after
// BEHAVIOUR
//  Reset: state=IDLE; RDADDR=0, BUSY=0, DOUT_VALID=0, DOUT_ADDR=0, DOUT_DATA=0, DONE=0, CHECKSUM=0.
//  FSM IDLE -> SETTLE -> SEND -> (SETTLE | FINISH) -> IDLE.
//   IDLE:   START=1 -> BUSY<=1, RDADDR<=0, settle_cnt<=0, sum<=0, go SETTLE. DONE low.
//   SETTLE: RDADDR held; settle_cnt increments each cycle. When settle_cnt==SETTLE_CYC-1:
//           DOUT_DATA<=REGDATA, DOUT_ADDR<=RDADDR, DOUT_VALID<=1, go SEND.
//   SEND:   DOUT_VALID/ADDR/DATA held stable while DOUT_READY=0 (no retraction, no change).
//           On VALID&READY: sum<=sum+DOUT_DATA and DOUT_VALID<=0.
//           If RDADDR==NUM_REGS-1, go FINISH. Otherwise RDADDR<=RDADDR+1, settle_cnt<=0, go SETTLE.
//   FINISH: DONE=1 and CHECKSUM=sum for exactly one cycle; BUSY<=0; go IDLE.
//  Latency: START edge -> first VALID = SETTLE_CYC+1 edges. Per beat with READY tied high = SETTLE_CYC+1 cycles.
//   Full scan (READY=1) = NUM_REGS*(SETTLE_CYC+1)+1 cycles to DONE.
//  START while BUSY: ignored; no restart, no queueing. START held high through FINISH re-arms in the next IDLE cycle.
//  ABORT (any non-IDLE state): next edge -> IDLE, BUSY=0, DOUT_VALID=0, no DONE, CHECKSUM unchanged.
//   ABORT has priority over a same-cycle handshake; that beat is not counted.
//  Checksum: wraps mod 2**DATA_W, no carry out.
//  REGDATA is sampled only in the final SETTLE cycle; changes at other times are ignored.
//   A register written mid-scan is reported with whatever value it holds when sampled.
//  RDADDR never exceeds NUM_REGS-1; the address counter does not wrap past the last register.
//  Async RESET_N low mid-scan: all outputs return to reset values immediately; no partial DONE.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE, S_SETTLE, S_SEND, S_FINISH) and the
//   ADDR_W/DATA_W defaults used with reg_file.
//  Single module with one state register block, next-state logic and a datapath block (addr counter, settle counter, sum).
//  No sub-module needed; the settle counter is under 4 bits and stays inline.
// TESTING
//  1 Preload regs with 8'd1..8'd8, READY=1, START pulse -> 8 beats addr 0..7, data 1..8;
//    DONE at cycle 17 (SETTLE_CYC=1); CHECKSUM=8'd36.
//  2 Backpressure: READY low for 5 cycles during beat addr 3 -> VALID, ADDR=3 and DATA held constant;
//    beat count stays 8; CHECKSUM unchanged vs test 1.
//  3 Wrap: all regs 8'hFF -> CHECKSUM=8'hF8.
//  4 START pulsed again at beat 2 -> ignored, a single DONE; START held high -> a second scan begins the cycle after DONE.
//  5 ABORT during SEND of addr 5 with READY=1 same cycle -> no handshake counted, BUSY=0 next edge, no DONE;
//    next START rescans from addr 0.
//  6 RESET_N asserted at beat 4 -> all outputs zero asynchronously; after release, START -> full clean scan with correct checksum.

Source files
------------

// File: rtl/reg_file_dumper_pkg.sv
// Shared definitions for the register-file dump engine: default geometry and FSM state encoding.
package reg_file_dumper_pkg;

   localparam int unsigned DEF_NUM_REGS   = 8;
   localparam int unsigned DEF_ADDR_W     = 3;
   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_SETTLE_CYC = 1;

   // Settle counter only needs to reach SETTLE_CYC-1 with SETTLE_CYC <= 3.
   localparam int unsigned SETTLE_CNT_W   = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SEND   = 2'd2,
      S_FINISH = 2'd3
   } dump_state_e;

endpackage

// File: rtl/reg_file_dumper.sv
// Walks every register through one read port, streams {addr,data} beats over VALID/READY,
// then pulses DONE with a wrapping 8-bit checksum of all beats.
module reg_file_dumper
   import reg_file_dumper_pkg::*;
#(
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              ABORT,
   output logic [ADDR_W-1:0] RDADDR,
   input  logic [DATA_W-1:0] REGDATA,
   output logic              BUSY,
   output logic              DOUT_VALID,
   input  logic              DOUT_READY,
   output logic [ADDR_W-1:0] DOUT_ADDR,
   output logic [DATA_W-1:0] DOUT_DATA,
   output logic              DONE,
   output logic [DATA_W-1:0] CHECKSUM
);

   localparam logic [ADDR_W-1:0]       LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

   dump_state_e             state;
   dump_state_e             state_nxt;
   logic [SETTLE_CNT_W-1:0] settle_cnt;
   logic [DATA_W-1:0]       sum;

   logic abort_c;
   logic settle_done_c;
   logic handshake_c;
   logic last_addr_c;

   // ABORT only matters once a scan is running, and it outranks a same-cycle handshake.
   assign abort_c       = ABORT && (state != S_IDLE);
   assign settle_done_c = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
   assign handshake_c   = (state == S_SEND) && DOUT_VALID && DOUT_READY;
   assign last_addr_c   = (RDADDR == LAST_ADDR);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort_c) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (START) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_done_c) state_nxt = S_SEND;
            S_SEND: begin
               if (handshake_c) state_nxt = last_addr_c ? S_FINISH : S_SETTLE;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath: address walk, settle timing, beat register, running sum and result.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         RDADDR     <= '0;
         BUSY       <= 1'b0;
         DOUT_VALID <= 1'b0;
         DOUT_ADDR  <= '0;
         DOUT_DATA  <= '0;
         DONE       <= 1'b0;
         CHECKSUM   <= '0;
         settle_cnt <= '0;
         sum        <= '0;
      end else if (abort_c) begin
         BUSY       <= 1'b0;
         DOUT_VALID <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  BUSY       <= 1'b1;
                  RDADDR     <= '0;
                  settle_cnt <= '0;
                  sum        <= '0;
               end
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
               if (settle_done_c) begin
                  DOUT_DATA  <= REGDATA;
                  DOUT_ADDR  <= RDADDR;
                  DOUT_VALID <= 1'b1;
               end
            end
            S_SEND: begin
               if (handshake_c) begin
                  sum        <= sum + DOUT_DATA;
                  DOUT_VALID <= 1'b0;
                  if (last_addr_c) begin
                     DONE     <= 1'b1;
                     CHECKSUM <= sum + DOUT_DATA;
                  end else begin
                     RDADDR     <= RDADDR + ADDR_W'(1);
                     settle_cnt <= '0;
                  end
               end
            end
            S_FINISH: begin
               DONE <= 1'b0;
               BUSY <= 1'b0;
            end
            default: begin
               DONE <= 1'b0;
               BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: full scans, backpressure, wrap, START/ABORT/reset corner cases.
module tb_reg_file_dumper;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned BUDGET   = 200;

   logic              CLK;
   logic              RESET_N;
   logic              START;
   logic              ABORT;
   logic [ADDR_W-1:0] RDADDR;
   logic [DATA_W-1:0] REGDATA;
   logic              BUSY;
   logic              DOUT_VALID;
   logic              DOUT_READY;
   logic [ADDR_W-1:0] DOUT_ADDR;
   logic [DATA_W-1:0] DOUT_DATA;
   logic              DONE;
   logic [DATA_W-1:0] CHECKSUM;

   logic [DATA_W-1:0] regs [NUM_REGS];

   int vectors    = 0;
   int miscompares = 0;
   int edge_cnt   = 0;

   int                mon_done = 0;
   logic [ADDR_W-1:0] mon_addr [$];
   logic [DATA_W-1:0] mon_data [$];

   reg_file_dumper #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SETTLE_CYC(1)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .START     (START),
      .ABORT     (ABORT),
      .RDADDR    (RDADDR),
      .REGDATA   (REGDATA),
      .BUSY      (BUSY),
      .DOUT_VALID(DOUT_VALID),
      .DOUT_READY(DOUT_READY),
      .DOUT_ADDR (DOUT_ADDR),
      .DOUT_DATA (DOUT_DATA),
      .DONE      (DONE),
      .CHECKSUM  (CHECKSUM)
   );

   assign REGDATA = regs[RDADDR];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Beats that will handshake at the coming posedge, and DONE pulses, seen mid-cycle.
   always @(negedge CLK) begin
      if (RESET_N && DOUT_VALID && DOUT_READY && !ABORT) begin
         mon_addr.push_back(DOUT_ADDR);
         mon_data.push_back(DOUT_DATA);
      end
      if (RESET_N && DONE) mon_done = mon_done + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      edge_cnt = edge_cnt + 1;
   endtask

   task automatic load_regs(input int base, input int step);
      for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(base + step * i);
   endtask

   task automatic start_scan();
      START    = 1'b1;
      edge_cnt = 0;
      tick();
      START    = 1'b0;
   endtask

   task automatic wait_done(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < BUDGET; i++) begin
         if (DONE) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_beat(input int addr, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < BUDGET; i++) begin
         if (DOUT_VALID && (DOUT_ADDR == ADDR_W'(addr))) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RESET_N    = 1'b0;
      START      = 1'b0;
      ABORT      = 1'b0;
      DOUT_READY = 1'b1;
      load_regs(1, 1);
      #12;
      vectors++;
      if ({RDADDR, BUSY, DOUT_VALID, DOUT_ADDR, DOUT_DATA, DONE, CHECKSUM} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 0",
                  {RDADDR, BUSY, DOUT_VALID, DOUT_ADDR, DOUT_DATA, DONE, CHECKSUM});
      end
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      tick();
      vectors++;
      if (BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy: got %b required 0", BUSY);
      end
   endtask

   task automatic test_basic();
      bit to;
      int b0, d0;
      load_regs(1, 1);
      DOUT_READY = 1'b1;
      b0 = mon_addr.size();
      d0 = mon_done;
      start_scan();
      vectors++;
      if ({BUSY, DOUT_VALID, RDADDR} !== {1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL basic_accept: busy/valid/rdaddr got %b%b%0d required 1 0 0", BUSY, DOUT_VALID, RDADDR);
      end
      tick();
      vectors++;
      if ({DOUT_VALID, DOUT_ADDR, DOUT_DATA} !== {1'b1, 3'd0, 8'd1}) begin
         miscompares++;
         $display("FAIL basic_first_beat: got v=%b a=%0d d=%0d required v=1 a=0 d=1", DOUT_VALID, DOUT_ADDR, DOUT_DATA);
      end
      wait_done(to);
      vectors++;
      if (to || edge_cnt != 17) begin
         miscompares++;
         $display("FAIL basic_done_edge: got %0d (timeout %0d) required 17", edge_cnt, to);
      end
      vectors++;
      if (CHECKSUM !== 8'd36 || BUSY !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_checksum: got %0d busy %b required 36 busy 1", CHECKSUM, BUSY);
      end
      tick();
      vectors++;
      if ({DONE, BUSY, CHECKSUM} !== {1'b0, 1'b0, 8'd36}) begin
         miscompares++;
         $display("FAIL basic_after_done: done=%b busy=%b cks=%0d required 0 0 36", DONE, BUSY, CHECKSUM);
      end
      vectors++;
      if (mon_addr.size() - b0 != 8 || mon_done - d0 != 1) begin
         miscompares++;
         $display("FAIL basic_counts: beats %0d dones %0d required 8 1", mon_addr.size() - b0, mon_done - d0);
      end
      for (int k = 0; k < 8; k++) begin
         if (b0 + k < mon_addr.size()) begin
            vectors++;
            if (mon_addr[b0 + k] !== ADDR_W'(k) || mon_data[b0 + k] !== DATA_W'(k + 1)) begin
               miscompares++;
               $display("FAIL basic_beat%0d: got a=%0d d=%0d required a=%0d d=%0d",
                        k, mon_addr[b0 + k], mon_data[b0 + k], k, k + 1);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int b0;
      load_regs(1, 1);
      DOUT_READY = 1'b1;
      b0 = mon_addr.size();
      start_scan();
      wait_beat(3, to);
      vectors++;
      if (to) begin
         miscompares++;
         $display("FAIL bp_reach_beat3: got timeout required beat 3");
      end
      DOUT_READY = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if ({DOUT_VALID, DOUT_ADDR, DOUT_DATA} !== {1'b1, 3'd3, 8'd4}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got v=%b a=%0d d=%0d required v=1 a=3 d=4", c, DOUT_VALID, DOUT_ADDR, DOUT_DATA);
         end
      end
      DOUT_READY = 1'b1;
      wait_done(to);
      vectors++;
      if (to || CHECKSUM !== 8'd36) begin
         miscompares++;
         $display("FAIL bp_checksum: got %0d (timeout %0d) required 36", CHECKSUM, to);
      end
      tick();
      vectors++;
      if (mon_addr.size() - b0 != 8) begin
         miscompares++;
         $display("FAIL bp_beats: got %0d required 8", mon_addr.size() - b0);
      end
   endtask

   task automatic test_wrap();
      bit to;
      load_regs(255, 0);
      DOUT_READY = 1'b1;
      start_scan();
      wait_done(to);
      vectors++;
      if (to || CHECKSUM !== 8'hF8) begin
         miscompares++;
         $display("FAIL wrap_checksum: got %h (timeout %0d) required f8", CHECKSUM, to);
      end
      tick();
   endtask

   task automatic test_start_while_busy();
      bit to;
      int d0;
      load_regs(1, 1);
      DOUT_READY = 1'b1;
      d0 = mon_done;
      start_scan();
      wait_beat(2, to);
      START = 1'b1;
      tick();
      START = 1'b0;
      wait_done(to);
      vectors++;
      if (to || edge_cnt != 17 || CHECKSUM !== 8'd36) begin
         miscompares++;
         $display("FAIL busy_start_ignored: done edge %0d cks %0d (timeout %0d) required 17 36", edge_cnt, CHECKSUM, to);
      end
      tick();
      vectors++;
      if (mon_done - d0 != 1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_single_done: dones %0d busy %b required 1 0", mon_done - d0, BUSY);
      end
      // START held high through the whole scan re-arms right after FINISH.
      START    = 1'b1;
      edge_cnt = 0;
      tick();
      wait_done(to);
      vectors++;
      if (to || edge_cnt != 17) begin
         miscompares++;
         $display("FAIL held_start_done: got edge %0d (timeout %0d) required 17", edge_cnt, to);
      end
      tick();
      vectors++;
      if ({DONE, BUSY} !== 2'b00) begin
         miscompares++;
         $display("FAIL held_start_idle: done/busy got %b%b required 00", DONE, BUSY);
      end
      tick();
      vectors++;
      if ({BUSY, RDADDR} !== {1'b1, 3'd0}) begin
         miscompares++;
         $display("FAIL held_start_rearm: busy=%b rdaddr=%0d required 1 0", BUSY, RDADDR);
      end
      START = 1'b0;
      wait_done(to);
      vectors++;
      if (to || CHECKSUM !== 8'd36) begin
         miscompares++;
         $display("FAIL held_start_second_cks: got %0d (timeout %0d) required 36", CHECKSUM, to);
      end
      tick();
   endtask

   task automatic test_abort();
      bit to;
      int b0, d0;
      load_regs(1, 1);
      DOUT_READY = 1'b1;
      b0 = mon_addr.size();
      d0 = mon_done;
      start_scan();
      wait_beat(5, to);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      vectors++;
      if (to || {BUSY, DOUT_VALID, DONE, CHECKSUM} !== {1'b0, 1'b0, 1'b0, 8'd36}) begin
         miscompares++;
         $display("FAIL abort_effect: busy=%b v=%b done=%b cks=%0d (timeout %0d) required 0 0 0 36",
                  BUSY, DOUT_VALID, DONE, CHECKSUM, to);
      end
      for (int c = 0; c < 3; c++) tick();
      vectors++;
      if (DONE !== 1'b0 || mon_done != d0 || mon_addr.size() - b0 != 5) begin
         miscompares++;
         $display("FAIL abort_no_done: done=%b dones %0d beats %0d required 0 0 5", DONE, mon_done - d0, mon_addr.size() - b0);
      end
      load_regs(2, 1);
      start_scan();
      tick();
      vectors++;
      if ({DOUT_VALID, DOUT_ADDR, DOUT_DATA} !== {1'b1, 3'd0, 8'd2}) begin
         miscompares++;
         $display("FAIL abort_rescan_first: got v=%b a=%0d d=%0d required 1 0 2", DOUT_VALID, DOUT_ADDR, DOUT_DATA);
      end
      wait_done(to);
      vectors++;
      if (to || CHECKSUM !== 8'd44) begin
         miscompares++;
         $display("FAIL abort_rescan_cks: got %0d (timeout %0d) required 44", CHECKSUM, to);
      end
      tick();
   endtask

   task automatic test_reset_midscan();
      bit to;
      int d0;
      load_regs(1, 1);
      DOUT_READY = 1'b1;
      d0 = mon_done;
      start_scan();
      wait_beat(4, to);
      #2;
      RESET_N = 1'b0;
      #1;
      vectors++;
      if (to || {RDADDR, BUSY, DOUT_VALID, DOUT_ADDR, DOUT_DATA, DONE, CHECKSUM} !== '0) begin
         miscompares++;
         $display("FAIL reset_midscan: got %h (timeout %0d) required 0",
                  {RDADDR, BUSY, DOUT_VALID, DOUT_ADDR, DOUT_DATA, DONE, CHECKSUM}, to);
      end
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      tick();
      load_regs(3, 1);
      start_scan();
      wait_done(to);
      vectors++;
      if (to || edge_cnt != 17 || CHECKSUM !== 8'd52) begin
         miscompares++;
         $display("FAIL reset_rescan: edge %0d cks %0d (timeout %0d) required 17 52", edge_cnt, CHECKSUM, to);
      end
      tick();
      vectors++;
      if (mon_done - d0 != 1) begin
         miscompares++;
         $display("FAIL reset_no_partial_done: got %0d dones required 1", mon_done - d0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_start_while_busy();
      test_abort();
      test_reset_midscan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
